// File: rtl/load_unit_if.sv
// Bundle between the MEM-stage pipeline control and the load unit, including the data-memory read port.
// The slave modport is the load unit; the master modport is the pipeline and memory environment.
interface load_unit_if;
  logic        start;
  logic [1:0]  size;
  logic        signedLoad;
  logic [31:0] addr;
  logic        busy;
  logic        done;
  logic [31:0] data;
  logic        addrError;
  logic        busError;
  logic        memReq;
  logic [31:0] memAddr;
  logic        memAck;
  logic [31:0] memRdata;

  modport slave (
    input  start, size, signedLoad, addr, memAck, memRdata,
    output busy, done, data, addrError, busError, memReq, memAddr
  );

  modport master (
    output start, size, signedLoad, addr, memAck, memRdata,
    input  busy, done, data, addrError, busError, memReq, memAddr
  );
endinterface

// File: rtl/load_unit.sv
// MEM-stage load sequencer: issues a word-aligned bus read, waits for the acknowledge,
// then selects the addressed byte or halfword lane and zero- or sign-extends it to 32 bits.
module load_unit #(
  parameter int TIMEOUT    = 16,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        rstN,
  load_unit_if.slave  bus
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic {IDLE, REQ} state_t;

  state_t           state;
  logic [1:0]       size_p0;
  logic [1:0]       off_p0;
  logic             sgn_p0;
  logic [CNT_W-1:0] cnt;
  logic             misaligned;

  // Lane select for the configured byte order, followed by zero or sign extension.
  function automatic logic [31:0] extend_lane(input logic [31:0] w, input logic [1:0] sz,
                                              input logic [1:0] off, input logic sgn);
    logic [1:0]         bsel;
    logic               hsel;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    bsel = BIG_ENDIAN ? ~off : off;
    hsel = BIG_ENDIAN ? ~off[1] : off[1];
    b    = w[{bsel, 3'b000} +: 8];
    h    = hsel ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   r = sgn ? 32'(b) : {24'b0, b};
      2'b01:   r = sgn ? 32'(h) : {16'b0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  always_comb begin
    misaligned = 1'b0;
    case (bus.size)
      2'b01:   misaligned = bus.addr[0];
      2'b10:   misaligned = |bus.addr[1:0];
      2'b11:   misaligned = 1'b1;
      default: misaligned = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state         <= IDLE;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.addrError <= 1'b0;
      bus.busError  <= 1'b0;
      bus.memReq    <= 1'b0;
      bus.data      <= '0;
      bus.memAddr   <= '0;
      cnt           <= '0;
      size_p0       <= '0;
      off_p0        <= '0;
      sgn_p0        <= 1'b0;
    end else begin
      bus.done      <= 1'b0;
      bus.addrError <= 1'b0;
      bus.busError  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (misaligned) begin
              bus.done      <= 1'b1;
              bus.addrError <= 1'b1;
              bus.data      <= '0;
            end else begin
              size_p0     <= bus.size;
              off_p0      <= bus.addr[1:0];
              sgn_p0      <= bus.signedLoad;
              bus.memAddr <= {bus.addr[31:2], 2'b00};
              bus.memReq  <= 1'b1;
              bus.busy    <= 1'b1;
              cnt         <= '0;
              state       <= REQ;
            end
          end
        end
        REQ: begin
          // An acknowledge in the last allowed cycle still completes normally.
          if (bus.memAck) begin
            bus.data   <= extend_lane(bus.memRdata, size_p0, off_p0, sgn_p0);
            bus.done   <= 1'b1;
            bus.memReq <= 1'b0;
            bus.busy   <= 1'b0;
            state      <= IDLE;
          end else if (TIMEOUT != 0 && cnt == TO_LAST) begin
            bus.data     <= '0;
            bus.done     <= 1'b1;
            bus.busError <= 1'b1;
            bus.memReq   <= 1'b0;
            bus.busy     <= 1'b0;
            state        <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_unit.sv
// Bench for load_unit: a big-endian and a little-endian instance (both TIMEOUT=4) run the
// same directed and random loads and are compared against an arithmetic reference model.
module tb_load_unit;

  logic        clk = 1'b0;
  logic        rstN;
  logic        start;
  logic [1:0]  size;
  logic        signedLoad;
  logic [31:0] addr;
  logic        memAck;
  logic [31:0] memRdata;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] last_be = '0;
  logic [31:0] last_le = '0;

  load_unit_if bus_be();
  load_unit_if bus_le();

  assign bus_be.start      = start;
  assign bus_be.size       = size;
  assign bus_be.signedLoad = signedLoad;
  assign bus_be.addr       = addr;
  assign bus_be.memAck     = memAck;
  assign bus_be.memRdata   = memRdata;
  assign bus_le.start      = start;
  assign bus_le.size       = size;
  assign bus_le.signedLoad = signedLoad;
  assign bus_le.addr       = addr;
  assign bus_le.memAck     = memAck;
  assign bus_le.memRdata   = memRdata;

  load_unit #(.TIMEOUT(4), .BIG_ENDIAN(1'b1)) u_be (.clk(clk), .rstN(rstN), .bus(bus_be.slave));
  load_unit #(.TIMEOUT(4), .BIG_ENDIAN(1'b0)) u_le (.clk(clk), .rstN(rstN), .bus(bus_le.slave));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit is_mis(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
  endfunction

  // k = byte position counted from bit 0 of the word.
  function automatic logic [31:0] model(input bit be, input logic [1:0] sz, input bit sgn,
                                        input logic [31:0] a, input logic [31:0] w);
    int unsigned k, nb, mask, v;
    if (sz == 2'd2) return w;
    if (sz == 2'd0) begin
      k  = be ? 32'd3 - 32'(a[1:0]) : 32'(a[1:0]);
      nb = 8;
    end else begin
      k  = be ? 32'd2 - 32'(a[1]) * 2 : 32'(a[1]) * 2;
      nb = 16;
    end
    mask = (32'd1 << nb) - 1;
    v    = (w >> (8 * k)) & mask;
    if (sgn && ((v >> (nb - 1)) & 1) == 1) v = v | ~mask;
    return v;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_done"}, 32'({bus_be.done, bus_le.done}), 32'd0);
    check({tag, "_err"}, 32'({bus_be.addrError, bus_be.busError, bus_le.addrError, bus_le.busError}), 32'd0);
    check({tag, "_req_busy"}, 32'({bus_be.memReq, bus_be.busy, bus_le.memReq, bus_le.busy}), 32'd0);
    check({tag, "_hold_be"}, bus_be.data, last_be);
    check({tag, "_hold_le"}, bus_le.data, last_le);
  endtask

  // Called and returns on a falling edge. ack_at = REQ cycle (1-based) carrying memAck;
  // outside 1..4 the load times out. chain leaves the caller in the done cycle.
  task automatic run_load(input logic [1:0] sz, input bit sgn, input logic [31:0] a,
                          input logic [31:0] w, input int ack_at, input bit chain, input bit poke);
    bit          got;
    bit          tmo;
    int          reqc;
    logic [31:0] exp_be, exp_le;
    start = 1'b1; size = sz; signedLoad = sgn; addr = a;
    @(posedge clk); @(negedge clk);
    start = 1'b0; addr = $urandom;
    if (is_mis(sz, a)) begin
      check("mis_done", 32'({bus_be.done, bus_le.done}), 32'd3);
      check("mis_addrerr", 32'({bus_be.addrError, bus_le.addrError}), 32'd3);
      check("mis_buserr", 32'({bus_be.busError, bus_le.busError}), 32'd0);
      check("mis_req_busy", 32'({bus_be.memReq, bus_be.busy, bus_le.memReq, bus_le.busy}), 32'd0);
      check("mis_data_be", bus_be.data, 32'd0);
      check("mis_data_le", bus_le.data, 32'd0);
      last_be = '0; last_le = '0;
    end else begin
      tmo    = (ack_at < 1 || ack_at > 4);
      exp_be = tmo ? 32'd0 : model(1'b1, sz, sgn, a, w);
      exp_le = tmo ? 32'd0 : model(1'b0, sz, sgn, a, w);
      reqc = 0; got = 1'b0;
      for (int i = 0; i < 12; i++) begin
        if (bus_be.done || bus_le.done) begin
          got = 1'b1;
          break;
        end
        reqc++;
        check("req_busy", 32'({bus_be.memReq, bus_be.busy, bus_le.memReq, bus_le.busy}), 32'hF);
        check("memaddr_be", bus_be.memAddr, {a[31:2], 2'b00});
        check("memaddr_le", bus_le.memAddr, {a[31:2], 2'b00});
        if (poke && reqc == 1) begin
          start = 1'b1; size = 2'd2; addr = {a[31:2], 2'b00} + 32'd4;
        end
        memAck   = (reqc == ack_at);
        memRdata = memAck ? w : $urandom;
        @(posedge clk); @(negedge clk);
        memAck = 1'b0; start = 1'b0;
      end
      check("done_seen", 32'(got), 32'd1);
      check("req_cycles", 32'(reqc), tmo ? 32'd4 : 32'(ack_at));
      check("ld_done", 32'({bus_be.done, bus_le.done}), 32'd3);
      check("ld_addrerr", 32'({bus_be.addrError, bus_le.addrError}), 32'd0);
      check("ld_buserr", 32'({bus_be.busError, bus_le.busError}), tmo ? 32'd3 : 32'd0);
      check("ld_req_busy", 32'({bus_be.memReq, bus_be.busy, bus_le.memReq, bus_le.busy}), 32'd0);
      check("ld_data_be", bus_be.data, exp_be);
      check("ld_data_le", bus_le.data, exp_le);
      last_be = exp_be; last_le = exp_le;
    end
    if (!chain) begin
      @(posedge clk); @(negedge clk);
      check_idle("after");
    end
  endtask

  initial begin
    rstN = 1'b0; start = 1'b0; size = 2'd0; signedLoad = 1'b0; addr = '0;
    memAck = 1'b0; memRdata = '0;
    @(negedge clk); @(negedge clk);
    check("rst_ctrl", 32'({bus_be.busy, bus_be.done, bus_be.addrError, bus_be.busError, bus_be.memReq,
                           bus_le.busy, bus_le.done, bus_le.addrError, bus_le.busError, bus_le.memReq}), 32'd0);
    check("rst_data", bus_be.data | bus_le.data, 32'd0);
    check("rst_memaddr", bus_be.memAddr | bus_le.memAddr, 32'd0);
    rstN = 1'b1;
    @(negedge clk);

    // Directed loads from the test plan.
    run_load(2'd0, 1'b1, 32'h1001, 32'h8899AABB, 3, 1'b0, 1'b0);
    run_load(2'd0, 1'b0, 32'h1001, 32'h8899AABB, 3, 1'b0, 1'b0);
    run_load(2'd1, 1'b1, 32'h1002, 32'h8899AABB, 1, 1'b0, 1'b0);
    run_load(2'd1, 1'b0, 32'h1002, 32'h8899AABB, 2, 1'b0, 1'b0);
    run_load(2'd2, 1'b1, 32'h1000, 32'h8899AABB, 1, 1'b0, 1'b0);
    run_load(2'd0, 1'b1, 32'h1000, 32'h8899AABB, 1, 1'b0, 1'b0);
    run_load(2'd1, 1'b1, 32'h1000, 32'h8899AABB, 2, 1'b0, 1'b0);
    run_load(2'd1, 1'b0, 32'h1003, 32'h8899AABB, 1, 1'b0, 1'b0);
    run_load(2'd2, 1'b0, 32'h1002, 32'h8899AABB, 1, 1'b0, 1'b0);
    run_load(2'd3, 1'b0, 32'h1000, 32'h8899AABB, 1, 1'b0, 1'b0);
    run_load(2'd2, 1'b0, 32'h2000, 32'h12345678, 0, 1'b0, 1'b0);
    run_load(2'd2, 1'b0, 32'h2004, 32'hCAFEF00D, 4, 1'b0, 1'b0);

    // Back-to-back with an ignored start while busy, then a misaligned load chained in.
    run_load(2'd2, 1'b0, 32'h3000, 32'hA5A5A5A5, 1, 1'b1, 1'b0);
    run_load(2'd1, 1'b1, 32'h3006, 32'h0000F00F, 3, 1'b1, 1'b1);
    run_load(2'd1, 1'b1, 32'h3001, 32'h0, 1, 1'b1, 1'b0);
    run_load(2'd0, 1'b1, 32'h3003, 32'h7F80017F, 2, 1'b0, 1'b0);

    // memAck while idle is ignored.
    memAck = 1'b1; memRdata = 32'hDEADBEEF;
    @(posedge clk); @(negedge clk);
    memAck = 1'b0;
    @(posedge clk); @(negedge clk);
    check_idle("idle_ack");

    // Reset in the middle of REQ aborts the load without a done.
    start = 1'b1; size = 2'd2; signedLoad = 1'b0; addr = 32'h4000;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    check("pre_rst_req", 32'({bus_be.memReq, bus_le.memReq}), 32'd3);
    @(posedge clk); @(negedge clk);
    rstN = 1'b0;
    #1;
    check("rst_async_req", 32'({bus_be.memReq, bus_be.busy, bus_le.memReq, bus_le.busy}), 32'd0);
    @(posedge clk); @(negedge clk);
    check("rst_no_done", 32'({bus_be.done, bus_le.done}), 32'd0);
    rstN = 1'b1;
    last_be = '0; last_le = '0;
    @(posedge clk); @(negedge clk);
    check_idle("post_rst");
    run_load(2'd2, 1'b0, 32'h1000, 32'h8899AABB, 2, 1'b0, 1'b0);

    // Random loads, including misaligned, reserved and timed-out ones.
    for (int n = 0; n < 60; n++) begin
      run_load(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom, $urandom,
               int'($urandom_range(1, 6)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    @(posedge clk); @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
